chan_scan_mux: RTL and testbench
================================

Name: chan_scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Successor to the team's combinational 8:1 one-bit gate-level mux.
- Adds a held channel-select register, an auto-scan mode that steps through channels with a programmable dwell time, and a registered output with a valid flag.
- Sits between multi-channel sample sources (switch banks, counters) and a single-lane consumer such as a display driver or serial transmitter.

Parameters:
- WIDTH, 8, bit width of each channel.
- CHANNELS, 8, number of input channels, 2..256.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 4, cycles spent on each channel in scan mode, >= 1.
- CNT_W, 2, dwell counter width; must satisfy 2**CNT_W >= DWELL.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- en  in  1  sample enable; 0 freezes all state.
- mode  in  1  0 = manual select, 1 = auto scan.
- load_sel  in  1  load sel_in into the select register.
- sel_in  in  SEL_W  requested channel.
- dout  out  WIDTH  registered selected data.
- sel_out  out  SEL_W  channel index that produced the current dout.
- valid  out  1  dout updated on the last edge.
- wrap  out  1  one-cycle pulse when scan passes from CHANNELS-1 back to 0.

Behaviour:
- All state is updated on the rising edge of clk only. No combinational path from any input to any output.
- Reset, when rst_n = 0 at an edge:
  - sel_q = 0, dwell count = 0, state = IDLE.
  - dout = 0, sel_out = 0, valid = 0, wrap = 0.
  - Reset mid-scan discards the current dwell and position.
- States:
  - IDLE: entered at reset. On the first edge with en = 1, go to MANUAL if mode = 0, or SCAN if mode = 1.
  - MANUAL: go to SCAN on an edge with en = 1 and mode = 1.
  - SCAN: go to MANUAL on an edge with en = 1 and mode = 0.
  - Mode is sampled only when en = 1.
- Sampling, on an edge with en = 1:
  - dout <= din[sel_q], sel_out <= sel_q, valid <= 1.
  - Latency is one clock from a din change to dout, and sel_out always names the channel that produced dout.
  - The register update uses the pre-edge sel_q. A select change on the same edge affects the next sample.
- Enable low, on an edge with en = 0: dout, sel_out, sel_q, dwell count and state all hold; valid <= 0; wrap <= 0.
- Manual select:
  - With en = 1 and load_sel = 1, sel_q <= sel_in.
  - If sel_in >= CHANNELS, the load is ignored and sel_q holds. No out-of-range channel is ever selected.
  - load_sel is honoured in every state, including IDLE.
- Scan stepping, in SCAN with en = 1:
  - Dwell count increments each edge.
  - When the count equals DWELL-1 it returns to 0 and sel_q advances by one. From CHANNELS-1 it goes to 0 and wrap <= 1 for exactly one cycle; otherwise wrap <= 0.
  - With DWELL = 1, sel_q advances every enabled edge.
- Entering SCAN (from IDLE or MANUAL) clears the dwell count and keeps sel_q, so each channel gets a full dwell.
- Simultaneous events: load_sel in SCAN has priority over a terminal dwell. sel_q <= sel_in (if in range), the dwell count clears and wrap stays 0.
- Leaving SCAN: the dwell count clears and sel_q freezes at its current value.

Test Plan:
- Reset: hold rst_n = 0 for 2 clocks with en = 1 and din non-zero -> dout = 0, sel_out = 0, valid = 0, wrap = 0. Release -> the first enabled edge gives dout = din[0], valid = 1.
- Manual: defaults; din channel k = 8'hA0+k, load_sel with sel_in = 5 -> the next edge still shows channel 0, the following edge gives dout = 8'hA5, sel_out = 5.
- Out of range: CHANNELS = 6, SEL_W = 3, load sel_in = 7 -> sel_q unchanged, dout keeps the previous channel's value.
- Scan: DWELL = 4, CHANNELS = 8, mode = 1, en = 1 for 40 cycles -> sel_out steps 0..7 with 4 cycles per channel; wrap pulses once, on the edge sel_q goes 7 -> 0; dout matches din[sel_out] one cycle late.
- Enable gaps in scan: drop en for 3 cycles mid-dwell -> valid = 0 and all outputs frozen; on resume the dwell continues from the frozen count, with no skipped or extra channel.
- Collision: in SCAN, assert load_sel with sel_in = 2 on the terminal-dwell edge of channel 7 -> sel_q = 2, wrap stays 0, and channel 2 then dwells a full 4 cycles.

Source files
------------

// File: rtl/chan_scan_mux.sv
// Registered N-channel W-bit mux with held select and auto-scan. One clock of latency from din to dout.
// No backpressure: en=0 freezes all state and drops valid. A select loaded on an edge applies from the next sample.
module chan_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load_sel,
  input  logic [SEL_W-1:0]          sel_in,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] sel_out_q, sel_out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic             load_ok;
  logic             cnt_last;
  logic [SEL_W-1:0] sel_next;

  // Padded to the full select range so any sel_q value indexes a defined entry.
  logic [WIDTH-1:0] chan [2**SEL_W];

  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_chan
    if (k < CHANNELS) begin : g_used
      assign chan[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  assign load_ok  = load_sel && ({1'b0, sel_in} < SEL_LIM);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    sel_out_d = sel_out_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;

    if (en) begin
      // Sample with the pre-edge select so sel_out always names dout's source.
      dout_d    = chan[sel_q];
      sel_out_d = sel_q;
      valid_d   = 1'b1;

      case (state_q)
        ST_IDLE: begin
          state_d = mode ? ST_SCAN : ST_MANUAL;
          cnt_d   = '0;
        end
        ST_MANUAL: begin
          if (mode) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            state_d = ST_MANUAL;
            cnt_d   = '0;
          end else if (load_ok) begin
            // An explicit load wins over a terminal dwell and restarts the dwell.
            cnt_d = '0;
          end else if (cnt_last) begin
            cnt_d  = '0;
            sel_d  = sel_next;
            wrap_d = (sel_q == SEL_LAST);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (load_ok) begin
        sel_d = sel_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      sel_out_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      sel_out_q <= sel_out_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dout    = dout_q;
  assign sel_out = sel_out_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: default 8-channel instance plus a 6-channel instance for out-of-range selects.
module tb_chan_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, load_sel;
  logic [2:0]  sel_in;
  logic [63:0] din;
  logic [47:0] din6;
  logic [7:0]  dout, dout6;
  logic [2:0]  sel_out, sel_out6;
  logic        valid, valid6, wrap, wrap6;

  typedef struct packed {
    logic [7:0] dout;
    logic [2:0] sel;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  chan_scan_mux u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode),
    .load_sel(load_sel), .sel_in(sel_in),
    .dout(dout), .sel_out(sel_out), .valid(valid), .wrap(wrap)
  );

  chan_scan_mux #(.CHANNELS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .en(en), .mode(mode),
    .load_sel(load_sel), .sel_in(sel_in),
    .dout(dout6), .sel_out(sel_out6), .valid(valid6), .wrap(wrap6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch(input logic [63:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input int s, input logic v, input logic w);
    exp_t e;
    e.dout  = d;
    e.sel   = 3'(s);
    e.valid = v;
    e.wrap  = w;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; load_sel = 1'b0; sel_in = '0;
    tick();
    tick();
    rst_n = 1'b1; en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e, g;
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'hB0 + k);
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; load_sel = 1'b0; sel_in = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin rst_n = 1'b1; load_sel = 1'b1; sel_in = 3'd3; end
      if (i == 3) load_sel = 1'b0;
      if (i == 4) en = 1'b0;
      case (i)
        0, 1:    sb.push_back(mk(8'h00, 0, 1'b0, 1'b0));
        2:       sb.push_back(mk(8'hA0, 0, 1'b1, 1'b0));
        3:       sb.push_back(mk(8'hA3, 3, 1'b1, 1'b0));
        default: sb.push_back(mk(8'hA3, 3, 1'b0, 1'b0));
      endcase
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset step%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 i, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_manual();
    exp_t e, g;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_sel = (i == 0); sel_in = 3'd5;
      if (i == 2) din[5*8 +: 8] = 8'h5C;
      case (i)
        0:       sb.push_back(mk(8'hA3, 3, 1'b1, 1'b0));
        1:       sb.push_back(mk(8'hA5, 5, 1'b1, 1'b0));
        default: sb.push_back(mk(8'h5C, 5, 1'b1, 1'b0));
      endcase
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL manual step%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 i, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e, g;
    din[5*8 +: 8] = 8'hA5;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_sel = (i < 2);
      sel_in   = (i == 0) ? 3'd6 : 3'd7;
      if (i == 3) din6[5*8 +: 8] = 8'h5E;
      case (i)
        0:       sb.push_back(mk(8'hA5, 5, 1'b1, 1'b0));
        1:       sb.push_back(mk(8'hA6, 6, 1'b1, 1'b0));
        default: sb.push_back(mk(8'hA7, 7, 1'b1, 1'b0));
      endcase
      sb.push_back(mk((i == 3) ? 8'h5E : 8'hB5, 5, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL range8 step%0d got dout=%h sel=%0d valid=%b need dout=%h sel=%0d valid=%b",
                 i, g.dout, g.sel, g.valid, e.dout, e.sel, e.valid);
      end
      e = sb.pop_front();
      g = mk(dout6, int'(sel_out6), valid6, wrap6);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL range6 step%0d got dout=%h sel=%0d valid=%b need dout=%h sel=%0d valid=%b",
                 i, g.dout, g.sel, g.valid, e.dout, e.sel, e.valid);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e, g;
    int   sel_pre, sel_post, n_wrap;
    do_reset();
    en = 1'b1; mode = 1'b1; load_sel = 1'b0;
    sel_pre = 0; n_wrap = 0;
    for (int j = 0; j < 40; j++) begin
      din = {$urandom, $urandom};
      sel_post = (j / 4) % 8;
      sb.push_back(mk(ch(din, sel_pre), sel_pre, 1'b1, (sel_pre == 7 && sel_post == 0)));
      tick();
      if (wrap === 1'b1) n_wrap++;
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scan j=%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 j, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
      sel_pre = sel_post;
    end
    n_run++;
    if (n_wrap !== 1) begin
      n_fail++;
      $display("FAIL scan_wrap_count got %0d need 1", n_wrap);
    end
  endtask

  task automatic test_enable_gap();
    exp_t e, g;
    int   j, sel_pre, sel_post, last_sel;
    logic [7:0] last_dout;
    do_reset();
    mode = 1'b1; load_sel = 1'b0;
    j = 0; sel_pre = 0; last_sel = 0; last_dout = '0;
    for (int c = 0; c < 19; c++) begin
      en  = !(c >= 6 && c < 9);
      din = {$urandom, $urandom};
      if (en) begin
        sel_post = (j / 4) % 8;
        last_dout = ch(din, sel_pre);
        last_sel  = sel_pre;
        sb.push_back(mk(last_dout, last_sel, 1'b1, (sel_pre == 7 && sel_post == 0)));
        sel_pre = sel_post;
        j++;
      end else begin
        sb.push_back(mk(last_dout, last_sel, 1'b0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL gap c=%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 c, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e, g;
    int   sel_pre, sel_post;
    do_reset();
    en = 1'b1; mode = 1'b1; sel_in = 3'd2;
    sel_pre = 0;
    for (int j = 0; j < 41; j++) begin
      load_sel = (j == 32);
      din = {$urandom, $urandom};
      sel_post = (j < 32) ? (j / 4) % 8 : 2 + (j - 32) / 4;
      sb.push_back(mk(ch(din, sel_pre), sel_pre, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL collision j=%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 j, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
      sel_pre = sel_post;
    end
    load_sel = 1'b0;
  endtask

  task automatic test_leave_scan();
    exp_t e, g;
    int   sel_tab [16] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    do_reset();
    en = 1'b1; load_sel = 1'b0;
    for (int j = 0; j < 16; j++) begin
      mode = !(j >= 6 && j <= 8);
      din  = {$urandom, $urandom};
      sb.push_back(mk(ch(din, sel_tab[j]), sel_tab[j], 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      g = mk(dout, int'(sel_out), valid, wrap);
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL leave_scan j=%0d got dout=%h sel=%0d valid=%b wrap=%b need dout=%h sel=%0d valid=%b wrap=%b",
                 j, g.dout, g.sel, g.valid, g.wrap, e.dout, e.sel, e.valid, e.wrap);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load_sel = 1'b0; sel_in = '0;
    din = '0; din6 = '0;
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan();
    test_enable_gap();
    test_collision();
    test_leave_scan();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
